inst_fetch_ctrl: RTL and testbench

- Fetch sequencer that owns the address port of the synchronous-read instruction ROM.
- Holds the PC, issues one word read per cycle, and absorbs the ROM's fixed 1-cycle read latency.
- Buffers returned words in a 2-entry queue and delivers them downstream over a valid/ready handshake.
- Handles branch/jump redirects by squashing all in-flight and buffered fetches.

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_skid_queue.sv | 57 +++++
 rtl/inst_fetch_ctrl.sv | 104 ++++++++++
 tb/tb_inst_fetch_ctrl.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch types and constants: queue depth, instruction width, default reset PC.
// The queue entry carries an instruction word together with the byte address it came from.
package fetch_pkg;

  localparam int          FETCH_QDEPTH   = 2;
  localparam int          INST_W         = 32;
  localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [31:0]       pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_queue.sv
// Two-entry FIFO of fetched words; the head is visible in the cycle after a push and is held while empty.
// Pops only when the head is valid. The caller never pushes when full. Flush empties the queue in one cycle.
module fetch_skid_queue
  import fetch_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  output fetch_entry_t head,
  output logic         head_valid,
  output logic [1:0]   occ
);

  fetch_entry_t ent0_q;
  fetch_entry_t ent1_q;
  logic [1:0]   occ_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      occ_q  <= 2'd0;
      ent0_q <= '0;
      ent1_q <= '0;
    end else if (flush) begin
      occ_q <= 2'd0;
    end else begin
      // ent0 is always the head; it only shifts when a second entry exists
      unique case ({push, pop})
        2'b10: begin
          if (occ_q == 2'd0) ent0_q <= push_entry;
          else               ent1_q <= push_entry;
          occ_q <= occ_q + 2'd1;
        end
        2'b01: begin
          if (occ_q == 2'd2) ent0_q <= ent1_q;
          occ_q <= occ_q - 2'd1;
        end
        2'b11: begin
          if (occ_q == 2'd2) begin
            ent0_q <= ent1_q;
            ent1_q <= push_entry;
          end else begin
            ent0_q <= push_entry;
          end
        end
        default: ;
      endcase
    end
  end

  assign head       = ent0_q;
  assign head_valid = (occ_q != 2'd0);
  assign occ        = occ_q;

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Fetch sequencer for a 1-cycle synchronous ROM; first word valid 2 cycles after issue, 1/cycle sustained.
// Issue stalls when queue+inflight would exceed 2; redirect squashes all. FETCH_BOUND_CHECK_EN adds a sticky range fault.
module inst_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int          ADDR_WIDTH = 8,
  parameter logic [31:0] RESET_PC   = FETCH_RESET_PC
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  output logic        fetch_fault
);

  if (ADDR_WIDTH < 1 || ADDR_WIDTH > 29) begin : g_addr_width_check
    $error("inst_fetch_ctrl: ADDR_WIDTH must be in 1..29");
  end
  if (RESET_PC[1:0] != 2'b00) begin : g_reset_pc_check
    $error("inst_fetch_ctrl: RESET_PC must be word aligned");
  end

  logic [31:0]  pc_q;
  logic [31:0]  req_pc_q;
  logic         inflight_q;
  logic [31:0]  redirect_base;
  fetch_entry_t head;
  fetch_entry_t push_entry;
  logic         head_valid;
  logic [1:0]   occ;
  logic         pop;
  logic         push;
  logic         room;
  logic         issue_ok;
  logic         issue;

  assign inst_valid    = head_valid && !redirect_valid;
  assign pop           = inst_valid && inst_ready;
  assign push          = inflight_q && !redirect_valid;
  assign push_entry    = '{inst: rom_data, pc: req_pc_q};
  assign redirect_base = redirect_pc & ~32'd3;

  // occ + inflight - pop <= 1, rearranged to avoid an unsigned underflow
  assign room     = ({1'b0, occ} + {2'b00, inflight_q}) <= (3'd1 + {2'b00, pop});
  assign issue_ok = !reset && !redirect_valid && room;

`ifdef FETCH_BOUND_CHECK_EN
  logic out_of_range;
  logic fault_q;

  assign out_of_range = |pc_q[31:ADDR_WIDTH+2];
  assign issue        = issue_ok && !fault_q && !out_of_range;
  assign fetch_fault  = fault_q;

  always_ff @(posedge clock) begin
    if (reset || redirect_valid) fault_q <= 1'b0;
    else if (issue_ok && out_of_range) fault_q <= 1'b1;
  end
`else
  assign issue       = issue_ok;
  assign fetch_fault = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
    end else if (redirect_valid) begin
      pc_q       <= redirect_base;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= issue;
      if (issue) begin
        pc_q     <= pc_q + 32'd4;
        req_pc_q <= pc_q;
      end
    end
  end

  assign rom_addr = pc_q;

  fetch_skid_queue u_queue (
    .clock      (clock),
    .reset      (reset),
    .flush      (redirect_valid),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .head_valid (head_valid),
    .occ        (occ)
  );

  assign inst_out = head.inst;
  assign inst_pc  = head.pc;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed bench for inst_fetch_ctrl with a 256-word synchronous ROM model (word i holds A000_0000 + i).
// Inputs change on the falling edge; outputs are checked 1 time unit later.
module tb_inst_fetch_ctrl;

  logic        clock;
  logic        reset;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic        fetch_fault;

  logic [31:0] rom [256];
  int n_checks = 0;
  int n_bad    = 0;

  inst_fetch_ctrl #(.ADDR_WIDTH(8), .RESET_PC(32'h0000_0000)) dut (
    .clock          (clock),
    .reset          (reset),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_out       (inst_out),
    .inst_pc        (inst_pc),
    .fetch_fault    (fetch_fault)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) rom_data <= reset ? 32'd0 : rom[rom_addr[9:2]];

  function automatic logic [31:0] w(input int i);
    return 32'hA000_0000 | 32'(i);
  endfunction

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic exp_inst(input string tag, input logic [31:0] inst, input logic [31:0] pc);
    expect_eq({tag, ".vld"}, {31'b0, inst_valid}, 32'd1);
    expect_eq({tag, ".inst"}, inst_out, inst);
    expect_eq({tag, ".pc"}, inst_pc, pc);
  endtask

  task automatic exp_idle(input string tag);
    expect_eq({tag, ".vld"}, {31'b0, inst_valid}, 32'd0);
  endtask

  task automatic cyc(input logic rst, input logic rdy, input logic rv, input logic [31:0] rpc);
    @(negedge clock);
    reset          = rst;
    inst_ready     = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    #1;
  endtask

  task automatic run(input logic rdy);
    cyc(1'b0, rdy, 1'b0, 32'd0);
  endtask

  task automatic redir(input logic [31:0] pc);
    cyc(1'b0, 1'b1, 1'b1, pc);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = w(i);
    reset = 1'b1; inst_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'd0;
    repeat (2) @(negedge clock);
    #1;
    expect_eq("rst.vld",   {31'b0, inst_valid}, 32'd0);
    expect_eq("rst.inst",  inst_out, 32'd0);
    expect_eq("rst.pc",    inst_pc, 32'd0);
    expect_eq("rst.fault", {31'b0, fetch_fault}, 32'd0);
    expect_eq("rst.addr",  rom_addr, 32'd0);

    // startup stream
    cyc(1'b0, 1'b1, 1'b0, 32'd0);
    expect_eq("c0.addr", rom_addr, 32'd0); exp_idle("c0");
    run(1); expect_eq("c1.addr", rom_addr, 32'd4); exp_idle("c1");
    run(1); expect_eq("c2.addr", rom_addr, 32'd8); exp_inst("c2", w(0), 32'd0);
    run(1); expect_eq("c3.addr", rom_addr, 32'd12); exp_inst("c3", w(1), 32'd4);
    run(1); exp_inst("c4", w(2), 32'd8);

    // five-cycle stall: two entries held, PC frozen
    run(0); expect_eq("st0.addr", rom_addr, 32'd20); exp_inst("st0", w(3), 32'd12);
    for (int i = 0; i < 4; i++) begin
      run(0);
      expect_eq("st.addr", rom_addr, 32'd20);
      exp_inst("st", w(3), 32'd12);
    end
    run(1); expect_eq("rel0.addr", rom_addr, 32'd20); exp_inst("rel0", w(3), 32'd12);
    run(1); expect_eq("rel1.addr", rom_addr, 32'd24); exp_inst("rel1", w(4), 32'd16);
    run(1); exp_inst("rel2", w(5), 32'd20);
    run(1); exp_inst("rel3", w(6), 32'd24);

    // redirect to 0x23 lands on word 8 at t+3
    redir(32'h23); exp_idle("rd.t0");
    run(1); exp_idle("rd.t1"); expect_eq("rd.addr", rom_addr, 32'h20);
    run(1); exp_idle("rd.t2");
    run(1); exp_inst("rd.t3", w(8), 32'h20);
    run(1); exp_inst("rd.t4", w(9), 32'h24);

    // redirect while full with ready high
    run(0); exp_inst("full", w(10), 32'h28);
    redir(32'h40); exp_idle("rdf.t0");
    run(1); exp_idle("rdf.t1"); expect_eq("rdf.addr", rom_addr, 32'h40);
    run(1); exp_idle("rdf.t2");
    run(1); exp_inst("rdf.t3", w(16), 32'h40);

    // back-to-back redirects, last wins
    redir(32'h100);
    redir(32'h80);
    run(1); expect_eq("b2b.addr", rom_addr, 32'h80); exp_idle("b2b.t1");
    run(1); exp_idle("b2b.t2");
    run(1); exp_inst("b2b.t3", w(32), 32'h80);
    run(1); exp_inst("b2b.t4", w(33), 32'h84);

    // one-cycle reset mid-stream
    cyc(1'b1, 1'b1, 1'b0, 32'd0);
    cyc(1'b0, 1'b1, 1'b0, 32'd0);
    expect_eq("mr.vld",   {31'b0, inst_valid}, 32'd0);
    expect_eq("mr.inst",  inst_out, 32'd0);
    expect_eq("mr.pc",    inst_pc, 32'd0);
    expect_eq("mr.fault", {31'b0, fetch_fault}, 32'd0);
    expect_eq("mr.addr",  rom_addr, 32'd0);
    run(1); expect_eq("mr1.addr", rom_addr, 32'd4);
    run(1); exp_inst("mr2", w(0), 32'd0);

    // top of the ROM window
    redir(32'h3F8);
    run(1); expect_eq("bnd.addr0", rom_addr, 32'h3F8);
    run(1); exp_idle("bnd.t2");
    run(1); exp_inst("bnd.t3", w(254), 32'h3F8); expect_eq("bnd.addr3", rom_addr, 32'h400);
    run(1); exp_inst("bnd.t4", w(255), 32'h3FC);
`ifdef FETCH_BOUND_CHECK_EN
    expect_eq("bnd.fault4", {31'b0, fetch_fault}, 32'd1);
    expect_eq("bnd.addr4", rom_addr, 32'h400);
    run(1); exp_idle("bnd.t5");
    expect_eq("bnd.fault5", {31'b0, fetch_fault}, 32'd1);
    expect_eq("bnd.addr5", rom_addr, 32'h400);
`else
    expect_eq("bnd.fault4", {31'b0, fetch_fault}, 32'd0);
    run(1); exp_inst("bnd.alias", w(0), 32'h400);
    expect_eq("bnd.addr5", rom_addr, 32'h408);
    expect_eq("bnd.fault5", {31'b0, fetch_fault}, 32'd0);
`endif
    redir(32'd0);
    run(1); expect_eq("clr.fault", {31'b0, fetch_fault}, 32'd0); expect_eq("clr.addr", rom_addr, 32'd0);
    run(1); exp_idle("clr.t2");
    run(1); exp_inst("clr.t3", w(0), 32'd0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
